// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller
// Decodes single-byte commands arriving from the UART receiver. It either
// pulses the send-enable controls or loads NUM_REGS threshold registers.
// Each register is assembled MSB-first from DATA_BYTES consecutive bytes.
// A load sequence is guarded by an inter-byte timeout. Unknown commands and
// timeouts are reported on a one-cycle cmd_error pulse. Every output is
// registered.

module uart_cmd_controller #(
  parameter int         DATA_BYTES     = 2,
  parameter int         NUM_REGS       = 2,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] CODE_SEND      = 8'h00,
  parameter logic [7:0] CODE_REG       = 8'h01,
  parameter logic [7:0] CODE_STOP      = 8'h02
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_ready,
  output logic                      en_send,
  output logic                      dis_send,
  output logic [NUM_REGS-1:0]       reg_wr,
  output logic [8*DATA_BYTES-1:0]   reg_data,
  output logic                      cmd_error,
  output logic                      busy
);

  localparam int W   = 8 * DATA_BYTES;
  localparam int BCW = $clog2(DATA_BYTES) + 1;
  localparam int RIW = $clog2(NUM_REGS) + 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BCW-1:0]      LAST_BYTE    = BCW'(DATA_BYTES - 1);
  localparam logic [RIW-1:0]      LAST_REG     = RIW'(NUM_REGS - 1);
  localparam logic [TOW-1:0]      LAST_TICK    = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REGS-1:0] ONE_HOT_BASE = NUM_REGS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    LOAD_WAIT = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     cmd;
  logic [BCW-1:0] byte_cnt;
  logic [RIW-1:0] reg_idx;
  logic [TOW-1:0] tcnt;
  logic [W-1:0]   asm_reg;

  // Command FSM: strobes default low each cycle so no pulse exceeds one
  // cycle. busy stays up through the cycle that carries the final strobe
  // and drops once the controller idles without a new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd       <= 8'h00;
      byte_cnt  <= '0;
      reg_idx   <= '0;
      tcnt      <= '0;
      asm_reg   <= '0;
      en_send   <= 1'b0;
      dis_send  <= 1'b0;
      reg_wr    <= '0;
      reg_data  <= '0;
      cmd_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      en_send   <= 1'b0;
      dis_send  <= 1'b0;
      cmd_error <= 1'b0;
      reg_wr    <= '0;

      case (state)
        IDLE: begin
          if (rx_ready) begin
            cmd   <= rx_data;
            state <= DECODE;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        DECODE: begin
          if (cmd == CODE_SEND) begin
            en_send <= 1'b1;
            state   <= IDLE;
          end else if (cmd == CODE_STOP) begin
            dis_send <= 1'b1;
            state    <= IDLE;
          end else if (cmd == CODE_REG) begin
            byte_cnt <= '0;
            reg_idx  <= '0;
            tcnt     <= '0;
            asm_reg  <= '0;
            state    <= LOAD_WAIT;
          end else begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end
        end

        LOAD_WAIT: begin
          if (rx_ready) begin
            asm_reg  <= (asm_reg << 8) | W'(rx_data);
            byte_cnt <= byte_cnt + 1'b1;
            tcnt     <= '0;
            if (byte_cnt == LAST_BYTE) begin
              state <= COMMIT;
            end
          end else if (tcnt == LAST_TICK) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        COMMIT: begin
          reg_wr   <= ONE_HOT_BASE << reg_idx;
          reg_data <= asm_reg;
          if (reg_idx == LAST_REG) begin
            state <= IDLE;
          end else begin
            reg_idx  <= reg_idx + 1'b1;
            byte_cnt <= '0;
            tcnt     <= '0;
            asm_reg  <= '0;
            state    <= LOAD_WAIT;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
